uart_rx_buffered: RTL and testbench

//  UART receiver (8N1, LSB first, no parity, no flow control) for the charlatan UART

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_buffered_if.sv | 24 ++
 rtl/uart_sync_fifo.sv | 62 ++++++
 rtl/uart_rx_buffered.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the charlatan receiver and transmitter: bit timing,
// frame width and the receive FSM state encoding.
package uart_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned BAUD   = 115_200;
  localparam int unsigned DATA_W = 8;

  // Clocks per bit, rounded to the nearest integer rather than truncated.
  function automatic int unsigned clks_per_bit_f(input int unsigned clk_hz,
                                                 input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  localparam int unsigned CLKS_PER_BIT = clks_per_bit_f(CLK_HZ, BAUD);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_rx_buffered_if.sv
// CPU-side register interface of the buffered UART receiver: enable, pop, error
// clear, and the queued byte with its status flags.
interface uart_rx_buffered_if;
  import uart_pkg::*;

  logic              rx_en;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] rx_data;
  logic              receive_flag;
  logic              overrun_flag;
  logic              frame_err;

  modport master (
    output rx_en, rd_en, clr_err,
    input  rx_data, receive_flag, overrun_flag, frame_err
  );

  modport slave (
    input  rx_en, rd_en, clr_err,
    output rx_data, receive_flag, overrun_flag, frame_err
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Small single-clock show-ahead FIFO: the head entry is visible combinationally
// and reads as zero while the queue is empty.
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full queue still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array carries no reset; only pointers and count need one,
  // since an entry is never observable before it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with a show-ahead receive queue and sticky overrun/framing flags.
// The rx pin is synchronised; the start bit is re-checked at mid-bit before sampling.
module uart_rx_buffered #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CLK_HZ     = uart_pkg::CLK_HZ,
  parameter int unsigned BAUD       = uart_pkg::BAUD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  uart_rx_buffered_if.slave  bus
);
  import uart_pkg::*;

  localparam int unsigned CPB       = clks_per_bit_f(CLK_HZ, BAUD);
  localparam int unsigned HALF      = CPB / 2;
  localparam int unsigned CW        = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  uart_state_e       state;
  uart_state_e       state_d;
  logic [1:0]        sync_q;
  logic              rxs;
  logic [CW-1:0]     baud_cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift;
  logic              cnt_clear;
  logic              take_bit;
  logic              push_byte;
  logic              frame_bad;
  logic              bit_tick;
  logic              half_tick;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              byte_dropped;
  logic              overrun_q;
  logic              frame_err_q;

  // Idle-high line: the synchroniser resets to 1 so reset never looks like a start bit.
  // NOTE: every clocked register uses non-blocking assignment so all flops sample
  // their inputs from the same edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rxs       = sync_q[1];
  assign bit_tick  = (baud_cnt == BIT_LAST);
  assign half_tick = (baud_cnt == HALF_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch can be inferred.
  always_comb begin
    state_d   = state;
    cnt_clear = 1'b0;
    take_bit  = 1'b0;
    push_byte = 1'b0;
    frame_bad = 1'b0;
    if (!bus.rx_en) begin
      state_d   = IDLE;
      cnt_clear = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_clear = 1'b1;
          if (!rxs) begin
            state_d = START;
          end
        end
        START: begin
          if (half_tick) begin
            cnt_clear = 1'b1;
            state_d   = rxs ? IDLE : DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            cnt_clear = 1'b1;
            take_bit  = 1'b1;
            if (bit_idx == 3'd7) begin
              state_d = STOP;
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            cnt_clear = 1'b1;
            state_d   = IDLE;
            push_byte = rxs;
            frame_bad = !rxs;
          end
        end
        default: begin
          state_d   = IDLE;
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      baud_cnt <= cnt_clear ? '0 : baud_cnt + CW'(1);
      if (state != DATA) begin
        bit_idx <= '0;
      end else if (take_bit) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (take_bit) begin
        shift[bit_idx] <= rxs;
      end
    end
  end

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_byte),
    .pop   (bus.rd_en),
    .din   (shift),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A simultaneous pop makes room, so only an unpaired push into a full queue drops.
  assign byte_dropped = push_byte && fifo_full && !bus.rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (byte_dropped) begin
        overrun_q <= 1'b1;
      end else if (bus.clr_err) begin
        overrun_q <= 1'b0;
      end
      if (frame_bad) begin
        frame_err_q <= 1'b1;
      end else if (bus.clr_err) begin
        frame_err_q <= 1'b0;
      end
    end
  end

  assign bus.rx_data      = fifo_head;
  assign bus.receive_flag = !fifo_empty;
  assign bus.overrun_flag = overrun_q;
  assign bus.frame_err    = frame_err_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: one instance at the nominal 434 clk/bit rate and one
// at 16 clk/bit for the longer directed and randomized sequences.
module tb_uart_rx_buffered;

  localparam int unsigned SYS_HZ    = 50_000_000;
  localparam int unsigned SLOW_BAUD = 115_200;
  localparam int unsigned FAST_BAUD = 3_125_000;
  localparam int CPB_A = (SYS_HZ + SLOW_BAUD / 2) / SLOW_BAUD;
  localparam int CPB_B = (SYS_HZ + FAST_BAUD / 2) / FAST_BAUD;
  localparam int FD    = 4;

  logic clk = 1'b0;
  logic rst;
  logic rx_a;
  logic rx_b;

  always #5 clk = ~clk;

  uart_rx_buffered_if bus_a ();
  uart_rx_buffered_if bus_b ();

  uart_rx_buffered #(.FIFO_DEPTH(FD)) dut_a (
    .clk (clk), .rst (rst), .rx (rx_a), .bus (bus_a)
  );

  uart_rx_buffered #(.FIFO_DEPTH(FD), .CLK_HZ(SYS_HZ), .BAUD(FAST_BAUD)) dut_b (
    .clk (clk), .rst (rst), .rx (rx_b), .bus (bus_b)
  );

  typedef struct {
    logic [7:0] data;
    bit         stop;
    bit         exp_flag;
    logic [7:0] exp_data;
    bit         exp_ferr;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int rise_at;

  logic [7:0] mq[$];
  bit         m_ovr;
  bit         m_ferr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_bus(input bit fast, input string name, input bit flag,
                           input logic [7:0] data, input bit ovr, input bit ferr);
    if (fast) begin
      check({name, ".receive_flag"}, bus_b.receive_flag, flag);
      check({name, ".rx_data"}, bus_b.rx_data, data);
      check({name, ".overrun_flag"}, bus_b.overrun_flag, ovr);
      check({name, ".frame_err"}, bus_b.frame_err, ferr);
    end else begin
      check({name, ".receive_flag"}, bus_a.receive_flag, flag);
      check({name, ".rx_data"}, bus_a.rx_data, data);
      check({name, ".overrun_flag"}, bus_a.overrun_flag, ovr);
      check({name, ".frame_err"}, bus_a.frame_err, ferr);
    end
  endtask

  task automatic set_rx(input bit fast, input logic v);
    if (fast) rx_b = v; else rx_a = v;
  endtask

  task automatic set_rd(input bit fast, input logic v);
    if (fast) bus_b.rd_en = v; else bus_a.rd_en = v;
  endtask

  task automatic set_en(input bit fast, input logic v);
    if (fast) bus_b.rx_en = v; else bus_a.rx_en = v;
  endtask

  task automatic set_clr(input bit fast, input logic v);
    if (fast) bus_b.clr_err = v; else bus_a.clr_err = v;
  endtask

  function automatic bit flag_of(input bit fast);
    return fast ? bus_b.receive_flag : bus_a.receive_flag;
  endfunction

  // One frame plus one idle bit time. Optional rd_en pulse at cycle pop_at; optional
  // abort at cycle abort_at: kind 1 drops rx_en for 3 clocks, kind 2 pulses rst and
  // leaves the line idle for the rest of the frame.
  task automatic send_frame(input bit fast, input logic [7:0] d, input bit stop,
                            input int pop_at, input int abort_at, input int abort_kind);
    int         cpb = fast ? CPB_B : CPB_A;
    logic [9:0] fr;
    bit         killed = 1'b0;
    bit         prev;
    bit         now;
    fr      = {stop, d, 1'b0};
    rise_at = -1;
    prev    = flag_of(fast);
    for (int c = 0; c < 11 * cpb; c++) begin
      @(negedge clk);
      now = flag_of(fast);
      if (!prev && now && rise_at < 0) rise_at = c;
      prev = now;
      if (abort_kind == 2 && c == abort_at) killed = 1'b1;
      set_rx(fast, (killed || c >= 10 * cpb) ? 1'b1 : fr[c / cpb]);
      set_rd(fast, c == pop_at);
      if (abort_kind == 1) set_en(fast, !(c >= abort_at && c < abort_at + 3));
      if (abort_kind == 2) rst = (c == abort_at);
    end
    @(negedge clk);
    set_rd(fast, 1'b0);
    set_en(fast, 1'b1);
    rst = 1'b0;
  endtask

  task automatic idle(input bit fast, input int n);
    repeat (n) begin
      @(negedge clk);
      set_rx(fast, 1'b1);
    end
  endtask

  task automatic pop(input bit fast);
    @(negedge clk);
    set_rd(fast, 1'b1);
    @(negedge clk);
    set_rd(fast, 1'b0);
  endtask

  task automatic clr(input bit fast);
    @(negedge clk);
    set_clr(fast, 1'b1);
    @(negedge clk);
    set_clr(fast, 1'b0);
  endtask

  task automatic check_model(input string name);
    check_bus(1'b1, name, mq.size() > 0, (mq.size() > 0) ? mq[0] : 8'h00, m_ovr, m_ferr);
  endtask

  initial begin
    vec_t tbl[6];
    logic [7:0] exp_seq[4];
    bit in_window;

    tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    tbl[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0};
    tbl[5] = '{8'h01, 1'b0, 1'b0, 8'h00, 1'b1};

    rst = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    bus_a.rx_en = 1'b1; bus_a.rd_en = 1'b0; bus_a.clr_err = 1'b0;
    bus_b.rx_en = 1'b1; bus_b.rd_en = 1'b0; bus_b.clr_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_bus(1'b0, "reset_a", 1'b0, 8'h00, 1'b0, 1'b0);
    check_bus(1'b1, "reset_b", 1'b0, 8'h00, 1'b0, 1'b0);

    // Nominal-rate byte; the flag must rise one clock after the stop-bit sample,
    // which sits half a bit plus the synchroniser/registration delay into the stop bit.
    send_frame(1'b0, 8'hA5, 1'b1, -1, -1, 0);
    in_window = (rise_at >= 9 * CPB_A + CPB_A / 2) && (rise_at <= 9 * CPB_A + CPB_A / 2 + 6);
    check("t1_rise_window", in_window, 1'b1);
    check_bus(1'b0, "t1_byte", 1'b1, 8'hA5, 1'b0, 1'b0);
    pop(1'b0);
    check_bus(1'b0, "t1_popped", 1'b0, 8'h00, 1'b0, 1'b0);

    // Short low glitch is rejected at mid start bit; receiver still works afterwards.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rx_a = 1'b0;
    end
    idle(1'b0, 700);
    check_bus(1'b0, "t2_glitch", 1'b0, 8'h00, 1'b0, 1'b0);
    send_frame(1'b0, 8'h5A, 1'b1, -1, -1, 0);
    check_bus(1'b0, "t2_recover", 1'b1, 8'h5A, 1'b0, 1'b0);
    pop(1'b0);

    for (int i = 0; i < 6; i++) begin
      send_frame(1'b1, tbl[i].data, tbl[i].stop, -1, -1, 0);
      check_bus(1'b1, $sformatf("tbl%0d", i), tbl[i].exp_flag, tbl[i].exp_data, 1'b0,
                tbl[i].exp_ferr);
      pop(1'b1);
      clr(1'b1);
      check_bus(1'b1, $sformatf("tbl%0d_drained", i), 1'b0, 8'h00, 1'b0, 1'b0);
    end

    // Five bytes into a four-deep queue: fifth dropped, overrun set.
    for (int i = 1; i <= 5; i++) send_frame(1'b1, 8'(i), 1'b1, -1, -1, 0);
    check_bus(1'b1, "t4_full", 1'b1, 8'h01, 1'b1, 1'b0);
    for (int i = 2; i <= 5; i++) begin
      pop(1'b1);
      check_bus(1'b1, $sformatf("t4_pop%0d", i - 1), i <= 4, (i <= 4) ? 8'(i) : 8'h00,
                1'b1, 1'b0);
    end
    clr(1'b1);
    check("t4_clr.overrun_flag", bus_b.overrun_flag, 1'b0);

    // Full queue, pop on the push cycle of 8'h77: both happen, no overrun.
    send_frame(1'b1, 8'h11, 1'b1, -1, -1, 0);
    send_frame(1'b1, 8'h22, 1'b1, -1, -1, 0);
    send_frame(1'b1, 8'h33, 1'b1, -1, -1, 0);
    send_frame(1'b1, 8'h44, 1'b1, -1, -1, 0);
    check_bus(1'b1, "t5_full", 1'b1, 8'h11, 1'b0, 1'b0);
    send_frame(1'b1, 8'h77, 1'b1, 2 + CPB_B / 2 + 9 * CPB_B, -1, 0);
    exp_seq = '{8'h22, 8'h33, 8'h44, 8'h77};
    for (int i = 0; i < 4; i++) begin
      check_bus(1'b1, $sformatf("t5_head%0d", i), 1'b1, exp_seq[i], 1'b0, 1'b0);
      pop(1'b1);
    end
    check_bus(1'b1, "t5_empty", 1'b0, 8'h00, 1'b0, 1'b0);

    // rx_en dropped at data bit 4 of 8'hFF, then a clean 8'h12.
    send_frame(1'b1, 8'hFF, 1'b1, -1, 5 * CPB_B + CPB_B / 2, 1);
    check_bus(1'b1, "t6_aborted", 1'b0, 8'h00, 1'b0, 1'b0);
    send_frame(1'b1, 8'h12, 1'b1, -1, -1, 0);
    send_frame(1'b1, 8'h3C, 1'b0, -1, -1, 0);
    check_bus(1'b1, "t6_pre_rst", 1'b1, 8'h12, 1'b0, 1'b1);
    send_frame(1'b1, 8'h55, 1'b1, -1, 4 * CPB_B, 2);
    check_bus(1'b1, "t6_after_rst", 1'b0, 8'h00, 1'b0, 1'b0);
    send_frame(1'b1, 8'h9E, 1'b1, -1, -1, 0);
    check_bus(1'b1, "t6_clean", 1'b1, 8'h9E, 1'b0, 1'b0);
    pop(1'b1);

    // Randomized traffic against a queue-based reference of the receiver's contract.
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    mq.delete();
    check_model("rand_start");
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      bit         good;
      int         npop;
      d    = 8'($urandom_range(0, 255));
      good = ($urandom_range(0, 7) != 0);
      send_frame(1'b1, d, good, -1, -1, 0);
      if (!good) m_ferr = 1'b1;
      else if (mq.size() < FD) mq.push_back(d);
      else m_ovr = 1'b1;
      idle(1'b1, $urandom_range(1, 20));
      check_model($sformatf("rand%0d_rx", n));
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) begin
        pop(1'b1);
        if (mq.size() > 0) void'(mq.pop_front());
        check_model($sformatf("rand%0d_pop%0d", n, k));
      end
      if ($urandom_range(0, 5) == 0) begin
        clr(1'b1);
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        check_model($sformatf("rand%0d_clr", n));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
